// File: rtl/coeff_ctx_idx_sequencer.sv
// ---------------------------------------------------------------------------
// coeff_ctx_idx_sequencer
//
// Producer side of the base-level handshake in the CABAC rate estimator.
// The block accepts the absolute levels of one coefficient group in scan
// order and tracks the greater1/greater2 context counters (c1Idx/c2Idx).
// For every nonzero level it requests a base level from base_level_calc and
// waits for the answer. It then emits the base level and the remaining level
// to the rate accumulator. Only one coefficient is in flight at a time.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   coeff_valid/coeff_ready/coeff_abs/coeff_first/coeff_last
//                   input coefficient stream (valid/ready)
//   start, c1Idx, c2Idx
//                   one-cycle request and context counters to base_level_calc
//   done, baseLevel one-cycle completion and result from base_level_calc
//   out_valid/out_ready/out_base/out_rem/out_rem_flag/out_last
//                   result stream to the rate accumulator (valid/ready)
//   cg_err          sticky flag: a CG ran past CG_SIZE coefficients
// ---------------------------------------------------------------------------
module coeff_ctx_idx_sequencer #(
  parameter int LEVEL_W = 16,
  parameter int C1_MAX  = 8,
  parameter int C2_MAX  = 1,
  parameter int CG_SIZE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  input  logic [LEVEL_W-1:0] coeff_abs,
  input  logic               coeff_first,
  input  logic               coeff_last,
  output logic               start,
  output logic [7:0]         c1Idx,
  output logic [7:0]         c2Idx,
  input  logic [7:0]         baseLevel,
  input  logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_base,
  output logic [LEVEL_W-1:0] out_rem,
  output logic               out_rem_flag,
  output logic               out_last,
  output logic               cg_err
);

  // Count range 0..CG_SIZE+1; it saturates at CG_SIZE+1.
  localparam int CNT_W = $clog2(CG_SIZE + 2);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  state_t             state;
  logic [LEVEL_W-1:0] abs_q;
  logic               last_q;
  logic [CNT_W-1:0]   cg_cnt;

  logic [CNT_W-1:0]   cg_num;    // position of the coefficient being accepted
  logic [LEVEL_W-1:0] base_ext;  // baseLevel zero-extended to the level width
  logic               g1_upd;
  logic               g2_upd;

  // c1Idx/c2Idx are the stored counters themselves. A coeff_first clears them
  // at accept time, so the request always sees the working value.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cg_num   = cg_cnt;
    base_ext = LEVEL_W'(baseLevel);
    g1_upd   = (c1Idx < 8'(C1_MAX));
    g2_upd   = g1_upd && (abs_q > LEVEL_W'(1)) && (c2Idx < 8'(C2_MAX));

    if (coeff_first) begin
      cg_num = CNT_W'(1);
    end else if (cg_cnt <= CNT_W'(CG_SIZE)) begin
      cg_num = cg_cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      abs_q        <= '0;
      last_q       <= 1'b0;
      cg_cnt       <= '0;
      coeff_ready  <= 1'b1;
      start        <= 1'b0;
      c1Idx        <= '0;
      c2Idx        <= '0;
      out_valid    <= 1'b0;
      out_base     <= '0;
      out_rem      <= '0;
      out_rem_flag <= 1'b0;
      out_last     <= 1'b0;
      cg_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (coeff_valid) begin
            abs_q       <= coeff_abs;
            last_q      <= coeff_last;
            coeff_ready <= 1'b0;
            cg_cnt      <= cg_num;
            if (cg_num > CNT_W'(CG_SIZE)) begin
              cg_err <= 1'b1;
            end
            if (coeff_first) begin
              c1Idx <= '0;
              c2Idx <= '0;
            end
            if (coeff_abs != '0) begin
              start <= 1'b1;
              state <= ISSUE;
            end else begin
              // Zero levels bypass base_level_calc entirely.
              out_valid    <= 1'b1;
              out_base     <= '0;
              out_rem      <= '0;
              out_rem_flag <= 1'b0;
              out_last     <= coeff_last;
              state        <= OUT;
            end
          end
        end

        ISSUE: begin
          start <= 1'b0;
          state <= WAIT;
        end

        WAIT: begin
          if (done) begin
            out_base  <= baseLevel;
            out_last  <= last_q;
            out_valid <= 1'b1;
            // abs_q is nonzero here, so the flag is just the no-underflow test.
            if (abs_q >= base_ext) begin
              out_rem      <= abs_q - base_ext;
              out_rem_flag <= 1'b1;
            end else begin
              out_rem      <= '0;
              out_rem_flag <= 1'b0;
            end
            state <= OUT;
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            coeff_ready <= 1'b1;
            state       <= IDLE;
            if (last_q) begin
              c1Idx  <= '0;
              c2Idx  <= '0;
              cg_cnt <= '0;
            end else if (abs_q != '0) begin
              // Both increments stop at their limits and never wrap.
              if (g1_upd) begin
                c1Idx <= c1Idx + 8'd1;
              end
              if (g2_upd) begin
                c2Idx <= c2Idx + 8'd1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_ctx_idx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_coeff_ctx_idx_sequencer
//
// Self-checking bench for coeff_ctx_idx_sequencer. It contains a registered
// model of base_level_calc (base = 1 + g1 + g2 from the request counters)
// and a reference model of the counters that predicts every result. The
// predicted results go into scoreboard queues, and monitors compare them
// with what the DUT produces.
// ---------------------------------------------------------------------------
module tb_coeff_ctx_idx_sequencer;

  localparam int LEVEL_W = 16;
  localparam int C1_MAX  = 8;
  localparam int C2_MAX  = 1;
  localparam int CG_SIZE = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               coeff_valid = 1'b0;
  logic               coeff_ready;
  logic [LEVEL_W-1:0] coeff_abs = '0;
  logic               coeff_first = 1'b0;
  logic               coeff_last = 1'b0;
  logic               start;
  logic [7:0]         c1Idx;
  logic [7:0]         c2Idx;
  logic [7:0]         baseLevel;
  logic               done;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [7:0]         out_base;
  logic [LEVEL_W-1:0] out_rem;
  logic               out_rem_flag;
  logic               out_last;
  logic               cg_err;

  always #5 clk = ~clk;

  coeff_ctx_idx_sequencer #(
    .LEVEL_W(LEVEL_W), .C1_MAX(C1_MAX), .C2_MAX(C2_MAX), .CG_SIZE(CG_SIZE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_abs(coeff_abs),
    .coeff_first(coeff_first), .coeff_last(coeff_last),
    .start(start), .c1Idx(c1Idx), .c2Idx(c2Idx),
    .baseLevel(baseLevel), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_base(out_base),
    .out_rem(out_rem), .out_rem_flag(out_rem_flag), .out_last(out_last),
    .cg_err(cg_err)
  );

  // ---------------- base_level_calc model ----------------
  function automatic int calc_base(input int c1, input int c2);
    int g1, g2;
    g1 = (c1 < C1_MAX) ? 1 : 0;
    g2 = (g1 == 1 && c2 < C2_MAX) ? 1 : 0;
    return 1 + g1 + g2;
  endfunction

  logic       calc_en = 1'b1;
  logic       done_model = 1'b0;
  logic [7:0] base_model = '0;
  logic       done_manual = 1'b0;
  logic [7:0] base_manual = '0;

  assign done      = done_model | done_manual;
  assign baseLevel = done_manual ? base_manual : base_model;

  always @(posedge clk) begin
    done_model <= calc_en && start;
    base_model <= 8'(calc_base(int'(c1Idx), int'(c2Idx)));
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0]         base;
    logic [LEVEL_W-1:0] rem;
    logic               flag;
    logic               last;
    logic               err;
  } exp_t;

  exp_t        out_q[$];
  logic [15:0] idx_q[$];
  int          start_cnt = 0;

  exp_t        e_mon;
  logic [15:0] idx_mon;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (out_q.size() == 0) begin
        check("unexpected_out", out_q.size(), 1);
      end else begin
        e_mon = out_q.pop_front();
        check("out_base", out_base, e_mon.base);
        check("out_rem", out_rem, e_mon.rem);
        check("out_rem_flag", out_rem_flag, e_mon.flag);
        check("out_last", out_last, e_mon.last);
        check("cg_err", cg_err, e_mon.err);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && start) begin
      start_cnt++;
      if (idx_q.size() == 0) begin
        check("unexpected_start", idx_q.size(), 1);
      end else begin
        idx_mon = idx_q.pop_front();
        check("start_c1Idx", c1Idx, idx_mon[15:8]);
        check("start_c2Idx", c2Idx, idx_mon[7:0]);
      end
    end
  end

  // ---------------- reference counter model ----------------
  int m_c1 = 0;
  int m_c2 = 0;
  int m_n = 0;
  bit m_err = 1'b0;

  // Predict the results for one coefficient and advance the model.
  task automatic predict(input int abs_v, input bit first, input bit last);
    exp_t e;
    int   base;
    if (first) begin
      m_c1 = 0;
      m_c2 = 0;
      m_n  = 1;
    end else begin
      m_n++;
    end
    if (m_n > CG_SIZE) m_err = 1'b1;
    if (abs_v != 0) begin
      base = calc_base(m_c1, m_c2);
      idx_q.push_back({8'(m_c1), 8'(m_c2)});
      e.base = 8'(base);
      e.rem  = (abs_v >= base) ? LEVEL_W'(abs_v - base) : '0;
      e.flag = (abs_v >= base);
    end else begin
      e.base = '0;
      e.rem  = '0;
      e.flag = 1'b0;
    end
    e.last = last;
    e.err  = m_err;
    out_q.push_back(e);
    if (abs_v != 0 && m_c1 < C1_MAX) begin
      if (abs_v > 1 && m_c2 < C2_MAX) m_c2++;
      m_c1++;
    end
    if (last) begin
      m_c1 = 0;
      m_c2 = 0;
      m_n  = 0;
    end
  endtask

  // Present one coefficient and hold it until the DUT accepts it.
  task automatic drive(input int abs_v, input bit first, input bit last);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    coeff_valid = 1'b1;
    coeff_abs   = LEVEL_W'(abs_v);
    coeff_first = first;
    coeff_last  = last;
    for (int i = 0; i < 60; i++) begin
      if (coeff_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    else check("accept_timeout", ok, 1);
    #1;
    coeff_valid = 1'b0;
    coeff_first = 1'b0;
    coeff_last  = 1'b0;
  endtask

  task automatic send(input int abs_v, input bit first, input bit last);
    predict(abs_v, first, last);
    drive(abs_v, first, last);
  endtask

  // Wait until every predicted result has been consumed, plus the handshake edge.
  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (out_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", out_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int s0;

  initial begin
    // T1: reset state
    repeat (2) @(negedge clk);
    check("rst_coeff_ready", coeff_ready, 1);
    check("rst_start", start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_c1Idx", c1Idx, 0);
    check("rst_c2Idx", c2Idx, 0);
    check("rst_cg_err", cg_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // T2: CG {3,1,2,0(last)}
    s0 = start_cnt;
    send(3, 1'b1, 1'b0);
    send(1, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0);
    send(0, 1'b0, 1'b1);
    drain();
    check("t2_start_pulses", start_cnt - s0, 3);
    check("t2_c1Idx_cleared", c1Idx, 0);
    check("t2_c2Idx_cleared", c2Idx, 0);

    // T3: c1Idx saturation
    send(5, 1'b1, 1'b0);
    for (int i = 1; i < 9; i++) send(5, 1'b0, 1'b0);
    drain();
    check("t3_c1Idx_sat", c1Idx, C1_MAX);
    check("t3_c2Idx_sat", c2Idx, C2_MAX);
    send(5, 1'b0, 1'b1);
    drain();

    // T4: output back-pressure
    out_ready = 1'b0;
    s0 = start_cnt;
    send(7, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check("t4_valid_seen", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_base", out_base, 3);
      check("t4_hold_rem", out_rem, 4);
      check("t4_hold_ready", coeff_ready, 0);
      @(negedge clk);
    end
    check("t4_one_start", start_cnt - s0, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // T5: coeff_first overrides stored counters, then CG overflow
    send(1, 1'b1, 1'b0);
    send(1, 1'b0, 1'b0);
    send(1, 1'b0, 1'b0);
    drain();
    check("t5_c1Idx_stored", c1Idx, 3);
    send(4, 1'b1, 1'b0);
    for (int i = 2; i <= 17; i++) begin
      send(4, 1'b0, 1'b0);
      if (i == 16) begin
        drain();
        check("t5_no_err_at_16", cg_err, 0);
      end
    end
    drain();
    check("t5_err_at_17", cg_err, 1);
    send(4, 1'b0, 1'b0);
    send(0, 1'b0, 1'b1);
    drain();
    check("t5_err_sticky", cg_err, 1);

    // T6: reset while waiting for done, then a stray done
    send(2, 1'b1, 1'b0);
    send(2, 1'b0, 1'b0);
    drain();
    calc_en = 1'b0;
    idx_q.push_back({8'(m_c1), 8'(m_c2)});
    drive(9, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    m_c1  = 0;
    m_c2  = 0;
    m_n   = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    base_manual = 8'd2;
    done_manual = 1'b1;
    @(negedge clk);
    done_manual = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t6_no_out_valid", out_valid, 0);
      check("t6_ready", coeff_ready, 1);
      @(negedge clk);
    end
    check("t6_c1Idx", c1Idx, 0);
    check("t6_c2Idx", c2Idx, 0);
    check("t6_cg_err", cg_err, 0);
    calc_en = 1'b1;
    send(4, 1'b0, 1'b1);
    drain();
    check("idx_q_empty", idx_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
